// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared definitions for the one-hot pulse decoder and its companion encoder.
//   CODE_W / LINES : code width and number of one-hot lines
//   CNT_W          : width of the pulse/gap down-counter
//   state_e        : decoder FSM states
//   code_to_onehot : MSB-index mapping, code k -> bit k of a [0:LINES-1] vector
package onehot_pulse_decoder_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Index 0 is the MSB on both sides: code 0 -> 8'b10000000, code 7 -> 8'b00000001.
  function automatic logic [0:LINES-1] code_to_onehot(input logic [0:CODE_W-1] code);
    logic [0:LINES-1] y;
    y       = '0;
    y[code] = 1'b1;
    return y;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder_if.sv
// Code-link bundle between a code source (master) and the pulse decoder (slave).
//   en         : block enable, driven by master
//   code_in    : 3-bit code, bit 0 is the MSB
//   code_valid : code_in is valid this cycle
//   code_ready : decoder can accept a code this cycle
//   y          : one-hot strobe output, index 0 is the MSB
//   y_valid    : y is non-zero
//   busy       : decoder is in PULSE or GAP
interface onehot_pulse_decoder_if;
  import onehot_pulse_decoder_pkg::*;

  logic              en;
  logic [0:CODE_W-1] code_in;
  logic              code_valid;
  logic              code_ready;
  logic [0:LINES-1]  y;
  logic              y_valid;
  logic              busy;

  modport master (
    output en, code_in, code_valid,
    input  code_ready, y, y_valid, busy
  );

  modport slave (
    input  en, code_in, code_valid,
    output code_ready, y, y_valid, busy
  );
endinterface

// File: rtl/onehot_dec_comb.sv
// Purely combinational 3-to-8 decode using the [0:7] MSB-index convention.
//   code_i : code to decode, bit 0 is the MSB
//   y_o    : one-hot result, code k sets y_o[k]
module onehot_dec_comb
  import onehot_pulse_decoder_pkg::*;
(
  input  logic [0:CODE_W-1] code_i,
  output logic [0:LINES-1]  y_o
);

  assign y_o = code_to_onehot(code_i);

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Sequential 3-to-8 decoder: accepts a code over valid/ready, drives the
// matching one-hot line for PULSE_LEN cycles, then holds GAP_LEN idle cycles.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : code link (slave side) -- en, code_in, code_valid in;
//         code_ready, y, y_valid, busy out
// Parameters: PULSE_LEN 1..255, GAP_LEN 0..255.
module onehot_pulse_decoder
  import onehot_pulse_decoder_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_pulse_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:LINES-1] y_q, y_d;
  logic [0:LINES-1] dec_y;
  logic             accept;

  onehot_dec_comb u_dec (
    .code_i (bus.code_in),
    .y_o    (dec_y)
  );

  // Gated by rst so the link sees "not ready" while the block is held in reset.
  assign bus.code_ready = bus.en && !rst && (state_q == IDLE);
  assign accept         = bus.code_valid && bus.code_ready;

  // NOTE: every variable is given its current value first so no path through
  // the case statement leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;

    if (!bus.en) begin
      // Abort: the interrupted pulse is dropped, not resumed.
      state_d = IDLE;
      cnt_d   = '0;
      y_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            // The decoded code is captured here, so later code_in changes are ignored.
            state_d = PULSE;
            cnt_d   = PULSE_INIT;
            y_d     = dec_y;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            y_d = '0;
            if (GAP_LEN > 0) begin
              state_d = GAP;
              cnt_d   = GAP_INIT;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          y_d     = '0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the asynchronous reset clears y without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = |y_q;
  assign bus.busy    = (state_q != IDLE);

endmodule
